ffo96_iter: RTL and testbench
=============================

FFO96_ITER -- requirements
Module: ffo96_iter

Interface
REQ-001 The module SHALL have parameter LSB_FIRST, default 0: 0 = emit indices highest bit first, 1 = lowest bit first.
REQ-002 The module SHALL have port rst, input, 1 bit: synchronous reset, active high.
REQ-003 The module SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port ld, input, 1 bit: load strobe for i.
REQ-005 The module SHALL have port i, input, 96 bits: bit vector to enumerate.
REQ-006 The module SHALL have port rdy, input, 1 bit: consumer accepts o this cycle.
REQ-007 The module SHALL have port vld, output, 1 bit: o holds a valid index.
REQ-008 The module SHALL have port o, output, 7 bits: index of the current set bit; 127 when vld=0.
REQ-009 The module SHALL have port busy, output, 1 bit: high in SCAN and DONE.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse at the end of enumeration.
REQ-011 The module SHALL have port cnt, output, 7 bits: number of indices accepted since the last load.

Function
REQ-012 The module SHALL hold a 96-bit mask register and a state register with states IDLE, SCAN and DONE.
REQ-013 In IDLE with ld=1, the module SHALL capture i into mask and clear cnt to 0.
REQ-014 In that same IDLE load cycle it SHALL go to SCAN if i!=0, and to DONE if i==0.
REQ-015 In IDLE with ld=0, state, mask and cnt SHALL hold.
REQ-016 The module SHALL ignore ld while in SCAN or DONE; mask, cnt and state are unaffected by it.
REQ-017 In SCAN, vld SHALL be 1.
REQ-018 In SCAN, o SHALL be the index of the most significant set bit of mask when LSB_FIRST=0, and of the least significant set bit when LSB_FIRST=1.
REQ-019 o SHALL be derived only from registered mask and state, never combinationally from i, ld or rdy.
REQ-020 In SCAN with rdy=1 (a transfer), the module SHALL clear bit o of mask and increment cnt by 1.
REQ-021 If that transfer consumes the last set bit of mask, the next state SHALL be DONE; otherwise it SHALL remain SCAN.
REQ-022 In SCAN with rdy=0, mask, cnt and o SHALL hold stable and vld SHALL stay 1.
REQ-023 Throughput SHALL be one index per cycle while rdy is held high.
REQ-024 Latency SHALL be: ld in cycle N gives vld=1 with the first index in cycle N+1.
REQ-025 In DONE, done SHALL be 1, vld SHALL be 0, o SHALL be 127 and cnt SHALL hold the final count.
REQ-026 DONE SHALL last exactly one cycle, after which the state is IDLE.
REQ-027 done SHALL be 0 in every state other than DONE.
REQ-028 Outside SCAN, vld SHALL be 0 and o SHALL be 127.
REQ-029 busy SHALL be 1 exactly in SCAN and DONE.
REQ-030 cnt SHALL be at most 96 and SHALL never wrap.
REQ-031 The index of bit 95 SHALL be 95 and of bit 0 SHALL be 0.
REQ-032 Each set bit of the loaded vector SHALL be emitted exactly once, in strict order, with no skipped and no repeated indices.
REQ-033 An all-ones load SHALL emit 96 indices, then done=1 with cnt=96.

Reset
REQ-034 When rst=1 at a clock edge, the module SHALL set state to IDLE, mask to 0 and cnt to 0.
REQ-035 While in reset, outputs SHALL be vld=0, o=127, busy=0 and done=0.
REQ-036 rst SHALL take priority over ld and rdy in the same cycle.
REQ-037 rst asserted during SCAN or DONE SHALL abort enumeration with no done pulse.
REQ-038 After rst deasserts, the module SHALL accept a load on the first cycle.

Verification
REQ-039 Scenario, LSB_FIRST=0: load i=96'h8000_0000_0000_0000_0000_0005 with rdy=1 -> o=95, 2, 0 on consecutive cycles, then done=1 with cnt=3, then IDLE.
REQ-040 Scenario, LSB_FIRST=1: same vector -> o=0, 2, 95, then done=1 with cnt=3.
REQ-041 Scenario: load i=0 -> no vld; done=1 in cycle N+1 with cnt=0 and o=127.
REQ-042 Scenario: load all-ones while rdy toggles with a random pattern -> o stable while rdy=0; 96 transfers 95..0 in order; done with cnt=96.
REQ-043 Scenario: ld pulsed with a different i during SCAN -> ignored; the original sequence completes unchanged.
REQ-044 Scenario: rst asserted mid-SCAN after 2 transfers -> next cycle vld=0, o=127, cnt=0, busy=0, no done pulse; a new load then works normally.

Source files
------------

// File: rtl/ffo96_iter.sv
// Iterates over the set bits of a 96-bit vector, emitting one bit index per accepted
// handshake, highest bit first (or lowest first when LSB_FIRST=1).
module ffo96_iter #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [95:0] i,
    input  logic        rdy,
    output logic        vld,
    output logic [6:0]  o,
    output logic        busy,
    output logic        done,
    output logic [6:0]  cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [95:0] mask_q, mask_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  sel_idx;

    // Priority encoder over the registered mask; the last match in loop order wins.
    always_comb begin
        sel_idx = 7'd0;
        if (LSB_FIRST) begin
            for (int k = 95; k >= 0; k--) begin
                if (mask_q[k]) sel_idx = k[6:0];
            end
        end else begin
            for (int k = 0; k < 96; k++) begin
                if (mask_q[k]) sel_idx = k[6:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ld) begin
                    mask_d  = i;
                    cnt_d   = 7'd0;
                    state_d = (i != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (rdy) begin
                    mask_d = mask_q & ~(96'd1 << sel_idx);
                    cnt_d  = cnt_q + 7'd1;
                    if (mask_d == '0) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        vld  = 1'b0;
        o    = 7'd127;
        busy = 1'b0;
        done = 1'b0;
        cnt  = cnt_q;
        if (!rst) begin
            unique case (state_q)
                SCAN: begin
                    vld  = 1'b1;
                    o    = sel_idx;
                    busy = 1'b1;
                end
                DONE: begin
                    busy = 1'b1;
                    done = 1'b1;
                end
                default: begin
                    vld = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ffo96_iter.sv
// Directed bench for ffo96_iter: runs an MSB-first and an LSB-first instance side by side
// on shared inputs and checks indices, handshake stalls, done pulse, counts and reset.
module tb_ffo96_iter;

    logic        clk;
    logic        rst;
    logic        ld;
    logic [95:0] i;
    logic        rdy;

    logic        vldA, busyA, doneA;
    logic [6:0]  oA, cntA;
    logic        vldB, busyB, doneB;
    logic [6:0]  oB, cntB;

    int errors = 0;
    int checks = 0;

    localparam logic [95:0] VEC3    = 96'h8000_0000_0000_0000_0000_0005;
    localparam logic [95:0] ALLONES = {96{1'b1}};

    ffo96_iter #(.LSB_FIRST(1'b0)) dutA (
        .clk(clk), .rst(rst), .ld(ld), .i(i), .rdy(rdy),
        .vld(vldA), .o(oA), .busy(busyA), .done(doneA), .cnt(cntA)
    );

    ffo96_iter #(.LSB_FIRST(1'b1)) dutB (
        .clk(clk), .rst(rst), .ld(ld), .i(i), .rdy(rdy),
        .vld(vldB), .o(oB), .busy(busyB), .done(doneB), .cnt(cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; ld = 1'b1; i = ALLONES; rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (vldA !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %0d expected 0", vldA); end
        checks++; if (oA !== 7'd127) begin errors++; $display("[TB] FAIL reset_o: got %0d expected 127", oA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0d expected 0", busyA); end
        checks++; if (doneA !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0d expected 0", doneA); end
        checks++; if (cntA !== 7'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cntA); end
        rst = 1'b0; ld = 1'b0; i = '0; rdy = 1'b0;
        @(negedge clk);
        checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy: got %0d expected 0", busyA); end
    endtask

    task automatic test_three_bits();
        int expA[3] = '{95, 2, 0};
        int expB[3] = '{0, 2, 95};
        ld = 1'b1; i = VEC3; rdy = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (vldA !== 1'b1) begin errors++; $display("[TB] FAIL msb_vld[%0d]: got %0d expected 1", k, vldA); end
            checks++; if (oA !== 7'(expA[k])) begin errors++; $display("[TB] FAIL msb_o[%0d]: got %0d expected %0d", k, oA, expA[k]); end
            checks++; if (oB !== 7'(expB[k])) begin errors++; $display("[TB] FAIL lsb_o[%0d]: got %0d expected %0d", k, oB, expB[k]); end
            checks++; if (cntA !== 7'(k)) begin errors++; $display("[TB] FAIL msb_cnt[%0d]: got %0d expected %0d", k, cntA, k); end
            checks++; if (doneA !== 1'b0) begin errors++; $display("[TB] FAIL msb_early_done[%0d]: got %0d expected 0", k, doneA); end
            @(negedge clk);
        end
        checks++; if (doneA !== 1'b1) begin errors++; $display("[TB] FAIL msb_done: got %0d expected 1", doneA); end
        checks++; if (doneB !== 1'b1) begin errors++; $display("[TB] FAIL lsb_done: got %0d expected 1", doneB); end
        checks++; if (cntA !== 7'd3) begin errors++; $display("[TB] FAIL msb_done_cnt: got %0d expected 3", cntA); end
        checks++; if (cntB !== 7'd3) begin errors++; $display("[TB] FAIL lsb_done_cnt: got %0d expected 3", cntB); end
        checks++; if (vldA !== 1'b0 || oA !== 7'd127) begin errors++; $display("[TB] FAIL msb_done_out: got vld=%0d o=%0d expected vld=0 o=127", vldA, oA); end
        checks++; if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL msb_done_busy: got %0d expected 1", busyA); end
        rdy = 1'b0;
        @(negedge clk);
        checks++; if (busyA !== 1'b0 || doneA !== 1'b0) begin errors++; $display("[TB] FAIL msb_back_idle: got busy=%0d done=%0d expected 0 0", busyA, doneA); end
        checks++; if (cntA !== 7'd3) begin errors++; $display("[TB] FAIL msb_idle_cnt: got %0d expected 3", cntA); end
    endtask

    task automatic test_zero_load();
        ld = 1'b1; i = '0; rdy = 1'b0;
        @(negedge clk);
        ld = 1'b0;
        checks++; if (vldA !== 1'b0) begin errors++; $display("[TB] FAIL zero_vld: got %0d expected 0", vldA); end
        checks++; if (doneA !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %0d expected 1", doneA); end
        checks++; if (cntA !== 7'd0) begin errors++; $display("[TB] FAIL zero_cnt: got %0d expected 0", cntA); end
        checks++; if (oA !== 7'd127) begin errors++; $display("[TB] FAIL zero_o: got %0d expected 127", oA); end
        @(negedge clk);
        checks++; if (busyA !== 1'b0 || doneA !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle: got busy=%0d done=%0d expected 0 0", busyA, doneA); end
    endtask

    task automatic test_allones_stall();
        int          expIdx = 95;
        int          cyc = 0;
        logic [7:0]  lfsr = 8'hA5;
        logic [6:0]  prevO = 7'd0;
        logic        prevRdy = 1'b0;
        ld = 1'b1; i = ALLONES; rdy = 1'b0;
        @(negedge clk);
        ld = 1'b0;
        while (expIdx >= 0 && cyc < 600) begin
            checks++; if (vldA !== 1'b1) begin errors++; $display("[TB] FAIL ones_vld@%0d: got %0d expected 1", cyc, vldA); end
            checks++; if (oA !== 7'(expIdx)) begin errors++; $display("[TB] FAIL ones_o@%0d: got %0d expected %0d", cyc, oA, expIdx); end
            checks++; if (cntA !== 7'(95 - expIdx)) begin errors++; $display("[TB] FAIL ones_cnt@%0d: got %0d expected %0d", cyc, cntA, 95 - expIdx); end
            if (cyc > 0 && !prevRdy) begin
                checks++; if (oA !== prevO) begin errors++; $display("[TB] FAIL ones_stall_o@%0d: got %0d expected %0d", cyc, oA, prevO); end
            end
            prevO = oA;
            rdy = lfsr[0];
            prevRdy = rdy;
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (rdy) expIdx--;
            cyc++;
            @(negedge clk);
        end
        rdy = 1'b0;
        if (expIdx >= 0) begin
            checks++; errors++;
            $display("[TB] FAIL ones_timeout: got %0d indices remaining expected 0", expIdx + 1);
        end
        checks++; if (doneA !== 1'b1) begin errors++; $display("[TB] FAIL ones_done: got %0d expected 1", doneA); end
        checks++; if (cntA !== 7'd96) begin errors++; $display("[TB] FAIL ones_cnt_final: got %0d expected 96", cntA); end
        @(negedge clk);
    endtask

    task automatic test_ld_ignored();
        int exp3[3] = '{90, 40, 7};
        ld = 1'b1; i = (96'd1 << 90) | (96'd1 << 40) | (96'd1 << 7); rdy = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (oA !== 7'(exp3[k])) begin errors++; $display("[TB] FAIL ldign_o[%0d]: got %0d expected %0d", k, oA, exp3[k]); end
            checks++; if (cntA !== 7'(k)) begin errors++; $display("[TB] FAIL ldign_cnt[%0d]: got %0d expected %0d", k, cntA, k); end
            ld = (k == 0);
            i  = (k == 0) ? 96'hFFFF : '0;
            @(negedge clk);
        end
        ld = 1'b0;
        checks++; if (doneA !== 1'b1 || cntA !== 7'd3) begin errors++; $display("[TB] FAIL ldign_done: got done=%0d cnt=%0d expected 1 3", doneA, cntA); end
        ld = 1'b1; i = ALLONES;
        @(negedge clk);
        ld = 1'b0; i = '0;
        checks++; if (busyA !== 1'b0 || vldA !== 1'b0) begin errors++; $display("[TB] FAIL ldign_done_ld: got busy=%0d vld=%0d expected 0 0", busyA, vldA); end
        rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int exp3[3] = '{95, 2, 0};
        ld = 1'b1; i = ALLONES; rdy = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (cntA !== 7'd2 || oA !== 7'd93) begin errors++; $display("[TB] FAIL rstmid_pre: got cnt=%0d o=%0d expected 2 93", cntA, oA); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (vldA !== 1'b0 || oA !== 7'd127) begin errors++; $display("[TB] FAIL rstmid_out: got vld=%0d o=%0d expected 0 127", vldA, oA); end
        checks++; if (cntA !== 7'd0) begin errors++; $display("[TB] FAIL rstmid_cnt: got %0d expected 0", cntA); end
        checks++; if (busyA !== 1'b0 || doneA !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy_done: got busy=%0d done=%0d expected 0 0", busyA, doneA); end
        rst = 1'b0;
        ld = 1'b1; i = VEC3;
        @(negedge clk);
        ld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (vldA !== 1'b1 || oA !== 7'(exp3[k])) begin errors++; $display("[TB] FAIL rstmid_reload_o[%0d]: got vld=%0d o=%0d expected 1 %0d", k, vldA, oA, exp3[k]); end
            @(negedge clk);
        end
        checks++; if (doneA !== 1'b1 || cntA !== 7'd3) begin errors++; $display("[TB] FAIL rstmid_reload_done: got done=%0d cnt=%0d expected 1 3", doneA, cntA); end
        rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; i = '0; rdy = 1'b0;
        test_reset();
        test_three_bits();
        test_zero_load();
        test_allones_stall();
        test_ld_ignored();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
